// File: rtl/mdr_result_out_pkg.sv
// -----------------------------------------------------------------------------
// mdr_result_out_pkg
// Shared types and constants for the MDR result output stage.
//   DW             : data width of result and remainder
//   RESULT_DEPTH   : default number of queued results
//   op_t           : operation code of a finished core operation
//   result_entry_t : one queued result {result, remainder, op, error}
//   occ_t          : queue occupancy classification (EMPTY / AVAIL / FULL)
//   entry_parity() : even parity (XOR reduction) over a result entry
// -----------------------------------------------------------------------------
package mdr_result_out_pkg;

    localparam int DW           = 16;
    localparam int RESULT_DEPTH = 4;

    typedef enum logic [1:0] {
        MUL  = 2'd0,
        DIV  = 2'd1,
        SQRT = 2'd2
    } op_t;

    typedef struct packed {
        logic [DW-1:0] result;
        logic [DW-1:0] remainder;
        op_t           op;
        logic          error;
    } result_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_AVAIL = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    function automatic logic entry_parity(input result_entry_t e);
        return ^e;
    endfunction

endpackage

// File: rtl/mdr_result_out_if.sv
// -----------------------------------------------------------------------------
// mdr_result_out_if
// Bundles the core-side result strobe, the downstream valid/ready handshake
// and the status outputs of mdr_result_out.
//   slave  : view of mdr_result_out (i_* in, o_* out)
//   master : view of the environment driving it (i_* out, o_* in)
// Optional: `MDR_RESULT_PARITY_EN adds o_parity (head entry even parity).
// -----------------------------------------------------------------------------
interface mdr_result_out_if
    import mdr_result_out_pkg::*;
#(
    parameter int DEPTH = RESULT_DEPTH,
    parameter int CW    = $clog2(DEPTH + 1)
) ();

    // core side
    logic          i_done;
    logic [DW-1:0] i_result;
    logic [DW-1:0] i_remainder;
    op_t           i_op;
    logic          i_error;
    logic          o_busy;
    // downstream side
    logic          i_ready;
    logic          o_valid;
    logic [DW-1:0] o_result;
    logic [DW-1:0] o_remainder;
    op_t           o_op;
    logic          o_error;
    // status / control
    logic          i_clr_ovf;
    logic [CW-1:0] o_count;
    logic          o_overflow;
`ifdef MDR_RESULT_PARITY_EN
    logic          o_parity;
`endif

    modport slave (
        input  i_done, i_result, i_remainder, i_op, i_error, i_ready, i_clr_ovf,
        output o_valid, o_result, o_remainder, o_op, o_error, o_busy, o_count,
        output o_overflow
`ifdef MDR_RESULT_PARITY_EN
        , output o_parity
`endif
    );

    modport master (
        output i_done, i_result, i_remainder, i_op, i_error, i_ready, i_clr_ovf,
        input  o_valid, o_result, o_remainder, o_op, o_error, o_busy, o_count,
        input  o_overflow
`ifdef MDR_RESULT_PARITY_EN
        , input o_parity
`endif
    );

endinterface

// File: rtl/mdr_result_out_fifo.sv
// -----------------------------------------------------------------------------
// mdr_result_out_fifo
// Generic DEPTH-entry register-array FIFO (DEPTH a power of two, >= 2).
//   clk, rst  : clock, synchronous active-high reset (pointers and count only)
//   push_i    : write request; accepted when not full or when a pop happens
//               in the same cycle
//   wdata_i   : write data
//   pop_i     : read request; ignored when empty
//   rdata_o   : head entry (stable until popped)
//   full_o    : count == DEPTH
//   empty_o   : count == 0
//   count_o   : current occupancy
// Storage is deliberately not reset; stale contents are never visible because
// the consumer qualifies rdata_o with !empty_o.
// -----------------------------------------------------------------------------
module mdr_result_out_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop from a full queue frees the slot the simultaneous push needs.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so natural AW-bit overflow wraps the pointers.
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mdr_result_out.sv
// -----------------------------------------------------------------------------
// mdr_result_out
// Output stage of the multiplier/divider/root unit. Finished results arrive
// as one-cycle i_done pulses, are queued, and are handed downstream over a
// valid/ready handshake.
//   clk, rst    : clock, synchronous active-high reset
//   bus (slave) : i_done/i_result/i_remainder/i_op/i_error from the core,
//                 o_busy back-pressure to the core,
//                 o_valid/i_ready + head data (o_result, o_remainder, o_op,
//                 o_error) to the consumer,
//                 o_count occupancy, o_overflow sticky drop flag, i_clr_ovf
// Optional: `MDR_RESULT_PARITY_EN stores an even-parity bit per entry and
// presents it on o_parity.
// -----------------------------------------------------------------------------
module mdr_result_out
    import mdr_result_out_pkg::*;
#(
    parameter int DEPTH = RESULT_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    mdr_result_out_if.slave   bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $bits(result_entry_t);
`ifdef MDR_RESULT_PARITY_EN
    localparam int EW = BW + 1;
`else
    localparam int EW = BW;
`endif

    result_entry_t in_entry;
    result_entry_t head;
    logic [EW-1:0] wdata;
    logic [EW-1:0] rdata;
    logic          full, empty;
    logic [CW-1:0] count;
    occ_t          occ;
    logic          valid, pop, ovf_evt;
    logic          ovf_q, ovf_d;

    assign in_entry = '{result:    bus.i_result,
                        remainder: bus.i_remainder,
                        op:        bus.i_op,
                        error:     bus.i_error};

`ifdef MDR_RESULT_PARITY_EN
    // Parity is computed once at push so the head output needs no XOR tree.
    assign wdata = {entry_parity(in_entry), in_entry};
`else
    assign wdata = in_entry;
`endif
    assign head = rdata[BW-1:0];

    mdr_result_out_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.i_done),
        .wdata_i (wdata),
        .pop_i   (pop),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_comb begin
        occ = OCC_AVAIL;
        if (empty)     occ = OCC_EMPTY;
        else if (full) occ = OCC_FULL;
    end

    assign valid = (occ != OCC_EMPTY);
    assign pop   = valid && bus.i_ready;

    // A done is only lost when the queue is full and nothing leaves this cycle.
    assign ovf_evt = bus.i_done && (occ == OCC_FULL) && !pop;

    always_comb begin
        ovf_d = ovf_q;
        if (bus.i_clr_ovf) ovf_d = 1'b0;
        if (ovf_evt)       ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    always_comb begin
        bus.o_valid     = valid;
        bus.o_busy      = (occ == OCC_FULL);
        bus.o_count     = count;
        bus.o_overflow  = ovf_q;
        bus.o_result    = '0;
        bus.o_remainder = '0;
        bus.o_op        = MUL;
        bus.o_error     = 1'b0;
`ifdef MDR_RESULT_PARITY_EN
        bus.o_parity    = 1'b0;
`endif
        // Data is zeroed while empty so stale storage never leaks out.
        if (valid) begin
            bus.o_result    = head.result;
            bus.o_remainder = head.remainder;
            bus.o_op        = head.op;
            bus.o_error     = head.error;
`ifdef MDR_RESULT_PARITY_EN
            bus.o_parity    = rdata[EW-1];
`endif
        end
    end

endmodule

// File: tb/tb_mdr_result_out.sv
// -----------------------------------------------------------------------------
// tb_mdr_result_out
// Directed scenarios followed by randomized traffic, all compared every cycle
// against a queue-based reference model of the result buffer.
// -----------------------------------------------------------------------------
module tb_mdr_result_out;
    import mdr_result_out_pkg::*;

    localparam int DEPTH = RESULT_DEPTH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdr_result_out_if #(.DEPTH(DEPTH)) bus ();

    mdr_result_out #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    result_entry_t mq[$];
    logic          m_ovf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        result_entry_t h;
        logic          v;
        v = (mq.size() > 0);
        h = v ? mq[0] : '0;
        chk("valid",     64'(bus.o_valid),     64'(v));
        chk("count",     64'(bus.o_count),     64'(mq.size()));
        chk("busy",      64'(bus.o_busy),      64'(mq.size() == DEPTH));
        chk("overflow",  64'(bus.o_overflow),  64'(m_ovf));
        chk("result",    64'(bus.o_result),    64'(h.result));
        chk("remainder", 64'(bus.o_remainder), 64'(h.remainder));
        chk("op",        64'(bus.o_op),        64'(h.op));
        chk("error",     64'(bus.o_error),     64'(h.error));
`ifdef MDR_RESULT_PARITY_EN
        chk("parity",    64'(bus.o_parity),    64'(v ? (^h) : 1'b0));
`endif
    endtask

    // Reference behaviour at a clock edge, from the current inputs.
    task automatic model_update();
        logic          pop, room;
        result_entry_t e;
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            pop  = (mq.size() > 0) && bus.i_ready;
            room = (mq.size() < DEPTH) || pop;
            e.result    = bus.i_result;
            e.remainder = bus.i_remainder;
            e.op        = bus.i_op;
            e.error     = bus.i_error;
            if (pop) void'(mq.pop_front());
            if (bus.i_done && room) mq.push_back(e);
            if (bus.i_done && !room) m_ovf = 1'b1;
            else if (bus.i_clr_ovf)  m_ovf = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_done      = 1'b0;
        bus.i_result    = '0;
        bus.i_remainder = '0;
        bus.i_op        = MUL;
        bus.i_error     = 1'b0;
        bus.i_clr_ovf   = 1'b0;
    endtask

    task automatic push(input logic [15:0] res, input logic [15:0] rem,
                        input op_t op, input logic err);
        bus.i_done      = 1'b1;
        bus.i_result    = res;
        bus.i_remainder = rem;
        bus.i_op        = op;
        bus.i_error     = err;
        tick();
        idle_inputs();
    endtask

    task automatic fill_four();
        bus.i_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push(16'(i), 16'h0, MUL, 1'b0);
    endtask

    initial begin
        m_ovf = 1'b0;
        rst   = 1'b1;
        bus.i_ready = 1'b0;
        idle_inputs();
        @(posedge clk); model_update(); #1;
        tick();
        rst = 1'b0;
        tick();

        // single result
        bus.i_ready = 1'b1;
        push(16'h0012, 16'h0000, MUL, 1'b0);
        chk("single_valid",  64'(bus.o_valid),  64'd1);
        chk("single_result", 64'(bus.o_result), 64'h12);
        tick();
        chk("single_drained", 64'(bus.o_count), 64'd0);

        // fill and back-pressure
        fill_four();
        chk("fill_busy",  64'(bus.o_busy),  64'd1);
        chk("fill_count", 64'(bus.o_count), 64'd4);
        repeat (10) tick();
        chk("fill_head_hold", 64'(bus.o_result), 64'd1);
        bus.i_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", 64'(bus.o_result), 64'(i));
            tick();
        end
        chk("drain_empty_valid", 64'(bus.o_valid),  64'd0);
        chk("drain_empty_data",  64'(bus.o_result), 64'd0);

        // overflow
        fill_four();
        push(16'h00FF, 16'h0, MUL, 1'b0);
        chk("ovf_set",   64'(bus.o_overflow), 64'd1);
        chk("ovf_count", 64'(bus.o_count),    64'd4);
        bus.i_clr_ovf = 1'b1;
        tick();
        bus.i_clr_ovf = 1'b0;
        chk("ovf_clr", 64'(bus.o_overflow), 64'd0);
        bus.i_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_drain", 64'(bus.o_result), 64'(i));
            tick();
        end

        // full push + pop
        fill_four();
        bus.i_ready = 1'b1;
        push(16'h0005, 16'h0, MUL, 1'b0);
        chk("fullpp_ovf",   64'(bus.o_overflow), 64'd0);
        chk("fullpp_count", 64'(bus.o_count),    64'd4);
        for (int i = 2; i <= 5; i++) begin
            chk("fullpp_drain", 64'(bus.o_result), 64'(i));
            tick();
        end

        // error passthrough
        bus.i_ready = 1'b0;
        push(16'hFFFF, 16'h0000, DIV, 1'b1);
        push(16'h0003, 16'h0000, MUL, 1'b0);
        chk("err_flag", 64'(bus.o_error), 64'd1);
        chk("err_op",   64'(bus.o_op),    64'(DIV));
        bus.i_ready = 1'b1;
        tick();
        chk("err_next_flag", 64'(bus.o_error), 64'd0);
        chk("err_next_op",   64'(bus.o_op),    64'(MUL));
        tick();

        // reset mid-operation
        bus.i_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(16'(16'h0100 + i), 16'h0, SQRT, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_valid", 64'(bus.o_valid),    64'd0);
        chk("rst_count", 64'(bus.o_count),    64'd0);
        chk("rst_busy",  64'(bus.o_busy),     64'd0);
        chk("rst_ovf",   64'(bus.o_overflow), 64'd0);
        push(16'h0AAA, 16'h0000, MUL, 1'b0);
        chk("rst_first_out", 64'(bus.o_result), 64'h0AAA);
`ifdef MDR_RESULT_PARITY_EN
        chk("rst_parity", 64'(bus.o_parity), 64'd0);
`endif
        bus.i_ready = 1'b1;
        tick();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bus.i_done      = ($urandom_range(0, 99) < 50);
            bus.i_result    = 16'($urandom);
            bus.i_remainder = 16'($urandom);
            bus.i_op        = op_t'($urandom_range(0, 2));
            bus.i_error     = ($urandom_range(0, 9) == 0);
            bus.i_ready     = ($urandom_range(0, 99) < 45);
            bus.i_clr_ovf   = ($urandom_range(0, 99) < 5);
            rst             = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
